seg_scan_mux: RTL and testbench

//   Time-multiplexed driver for a common-segment 7-seg display bank. Holds a frame of packed BCD

---
 rtl/seg_scan_mux_pkg.sv | 13 +
 rtl/digit_to_seg.sv | 25 ++
 rtl/seg_scan_mux.sv | 147 ++++++++++++++
 tb/tb_seg_scan_mux.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_mux_pkg.sv
// Shared encoding constants and slot state type for the 7-segment scan driver.
package seg_scan_mux_pkg;

    localparam logic [7:0]  SEG_BLANK  = 8'hFF;
    localparam int unsigned SEG_DP_BIT = 0;
    localparam logic [3:0]  BLANK_CODE = 4'hF;

    typedef enum logic {
        StBlank,
        StShow
    } slot_state_e;

endpackage

// File: rtl/digit_to_seg.sv
// Combinational BCD to active-low {a,b,c,d,e,f,g,dp} decoder; dp bit is always off.
module digit_to_seg
    import seg_scan_mux_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [7:0] o_seg
);

    always_comb begin
        case (i_code)
            4'd0:    o_seg = 8'h03;
            4'd1:    o_seg = 8'h9F;
            4'd2:    o_seg = 8'h25;
            4'd3:    o_seg = 8'h0D;
            4'd4:    o_seg = 8'h99;
            4'd5:    o_seg = 8'h49;
            4'd6:    o_seg = 8'h41;
            4'd7:    o_seg = 8'h1F;
            4'd8:    o_seg = 8'h01;
            4'd9:    o_seg = 8'h09;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment bank driver: blank/show slot FSM, shadowed frame with
// wrap-synchronous update handshake, leading-zero blanking and registered pin outputs.
module seg_scan_mux
    import seg_scan_mux_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned SCAN_HZ    = 1_000,
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned BLANK_CYC  = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_blank_en,
    input  logic                    upd,
    output logic                    upd_ack,
    output logic [NUM_DIGITS-1:0]   sel_n,
    output logic [7:0]              seg,
    output logic                    frame_tick
);

    localparam int unsigned DIV  = CLK_HZ / SCAN_HZ;
    localparam int unsigned CNTW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IDXW = $clog2(NUM_DIGITS);
    localparam logic [CNTW-1:0] CNT_LAST       = CNTW'(DIV - 1);
    localparam logic [CNTW-1:0] CNT_BLANK_LAST = CNTW'(BLANK_CYC - 1);
    localparam logic [IDXW-1:0] IDX_LAST       = IDXW'(NUM_DIGITS - 1);

    slot_state_e r_state, w_state_d;
    logic [CNTW-1:0] r_cnt, w_cnt_d;
    logic [IDXW-1:0] r_idx, w_idx_d;
    logic w_slot_end, w_wrap;

    logic                    r_pending, r_lz;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic [NUM_DIGITS-1:0]   r_sel_n, w_sel_d;
    logic [7:0]              r_seg, w_seg_d, w_dec;
    logic                    r_frame_tick, r_upd_ack;

    logic [3:0]            w_digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] w_zblank;
    logic [3:0]            w_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StBlank;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_idx   <= w_idx_d;
        end
    end

    always_comb begin
        w_slot_end = (r_cnt == CNT_LAST);
        w_wrap     = w_slot_end && (r_idx == IDX_LAST);
        w_cnt_d    = w_slot_end ? '0 : r_cnt + 1'b1;
        w_idx_d    = r_idx;
        if (w_slot_end) begin
            w_idx_d = w_wrap ? '0 : r_idx + 1'b1;
        end
        w_state_d = r_state;
        case (r_state)
            StBlank: if (r_cnt == CNT_BLANK_LAST) w_state_d = StShow;
            StShow:  if (w_slot_end)              w_state_d = StBlank;
            default: w_state_d = StBlank;
        endcase
    end

    // A digit is zero-blanked when it and every digit to its left are 0 with no dp lit.
    always_comb begin
        logic run;
        run      = r_lz;
        w_zblank = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_digit[i] = r_digits[4*i +: 4];
        end
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            run         = run & (w_digit[i] == 4'd0) & ~r_dp[i];
            w_zblank[i] = run;
        end
        w_code = w_zblank[r_idx] ? BLANK_CODE : w_digit[r_idx];
    end

    digit_to_seg u_digit_to_seg (
        .i_code (w_code),
        .o_seg  (w_dec)
    );

    always_comb begin
        w_sel_d = '1;
        w_seg_d = SEG_BLANK;
        if (r_state == StShow) begin
            w_sel_d[r_idx]      = 1'b0;
            w_seg_d             = w_dec;
            w_seg_d[SEG_DP_BIT] = ~r_dp[r_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_n      <= '1;
            r_seg        <= SEG_BLANK;
            r_frame_tick <= 1'b0;
            r_upd_ack    <= 1'b0;
        end else begin
            r_sel_n      <= w_sel_d;
            r_seg        <= w_seg_d;
            r_frame_tick <= w_wrap;
            r_upd_ack    <= w_wrap & (r_pending | upd);
        end
    end

    // Shadow only changes on the wrap edge, so a frame is never shown half-updated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
            r_digits  <= '0;
            r_dp      <= '0;
            r_lz      <= 1'b0;
        end else if (w_wrap) begin
            r_pending <= 1'b0;
            if (r_pending || upd) begin
                r_digits <= bcd_in;
                r_dp     <= dp_in;
                r_lz     <= lz_blank_en;
            end
        end else if (upd) begin
            r_pending <= 1'b1;
        end
    end

    assign sel_n      = r_sel_n;
    assign seg        = r_seg;
    assign frame_tick = r_frame_tick;
    assign upd_ack    = r_upd_ack;

    a_one_digit: assert property (@(posedge clk) disable iff (!rst_n)
        $countones(~sel_n) <= 1);
    a_blank_off: assert property (@(posedge clk) disable iff (!rst_n)
        ($past(r_state) == StBlank) |-> (sel_n == '1));

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: stimulus queues expected digit windows and acks,
// a negedge monitor pops and compares them as the display scans.
module tb_seg_scan_mux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in = '0;
    logic        lz_blank_en = 1'b0;
    logic        upd = 1'b0;
    logic        upd_ack, frame_tick;
    logic [3:0]  sel_n;
    logic [7:0]  seg;

    seg_scan_mux #(
        .CLK_HZ     (1000),
        .SCAN_HZ    (100),
        .NUM_DIGITS (4),
        .BLANK_CYC  (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bcd_in      (bcd_in),
        .dp_in       (dp_in),
        .lz_blank_en (lz_blank_en),
        .upd         (upd),
        .upd_ack     (upd_ack),
        .sel_n       (sel_n),
        .seg         (seg),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] seg;
    } show_t;

    show_t q_show[$];
    bit    q_ack[$];
    int    n_checks = 0;
    int    n_errors = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endfunction

    // segs holds the four expected seg bytes, digit 0 in the low byte.
    task automatic push_frame(input logic [31:0] segs);
        show_t e;
        for (int i = 0; i < 4; i++) begin
            e.sel = ~(4'b0001 << i);
            e.seg = segs[8*i +: 8];
            q_show.push_back(e);
        end
    endtask

    task automatic wait_tick();
        int k;
        for (k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (frame_tick) break;
        end
        check("frame_tick_wait", 32'(k < 100), 1);
    endtask

    task automatic issue(input logic [15:0] b, input logic [3:0] d, input logic lz);
        bcd_in      = b;
        dp_in       = d;
        lz_blank_en = lz;
        upd         = 1'b1;
        @(posedge clk);
        #1;
        upd = 1'b0;
    endtask

    initial begin : monitor
        logic [3:0] prev_sel;
        int         show_len, cyc, last_tick;
        bit         tick_valid, exp_ack;
        show_t      e;
        prev_sel   = '1;
        show_len   = 0;
        cyc        = 0;
        last_tick  = 0;
        tick_valid = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q_show.delete();
                q_ack.delete();
                prev_sel   = '1;
                show_len   = 0;
                tick_valid = 0;
            end else begin
                cyc++;
                if (prev_sel == 4'hF && sel_n != 4'hF) begin
                    check("show_queue_nonempty", 32'(q_show.size() != 0), 1);
                    if (q_show.size() != 0) begin
                        e = q_show.pop_front();
                        check("sel_n", sel_n, e.sel);
                        check("seg", seg, e.seg);
                    end
                    show_len = 1;
                end else if (sel_n != 4'hF) begin
                    show_len++;
                end
                if (prev_sel != 4'hF && sel_n == 4'hF) check("show_len", show_len, 8);
                if (frame_tick || upd_ack) begin
                    exp_ack = frame_tick && (q_ack.size() != 0);
                    if (exp_ack) void'(q_ack.pop_front());
                    check("upd_ack", upd_ack, exp_ack);
                    check("frame_tick_with_ack", frame_tick, 1);
                    if (frame_tick) begin
                        if (tick_valid) check("tick_period", cyc - last_tick, 40);
                        last_tick  = cyc;
                        tick_valid = 1;
                    end
                end
                prev_sel = sel_n;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        int k;
        repeat (3) @(posedge clk);
        #1;
        check("reset_sel_n", sel_n, 4'hF);
        check("reset_seg", seg, 8'hFF);
        check("reset_upd_ack", upd_ack, 0);
        check("reset_frame_tick", frame_tick, 0);
        rst_n = 1'b1;

        // Unloaded shadow shows 0 on every digit.
        push_frame(32'h03030303);
        push_frame(32'h03030303);
        wait_tick();

        issue(16'h0120, 4'b0000, 1'b1);
        push_frame(32'hFF9F2503);
        q_ack.push_back(1'b1);
        wait_tick();

        issue(16'h0005, 4'b0100, 1'b1);
        push_frame(32'hFF020349);
        q_ack.push_back(1'b1);
        wait_tick();

        issue(16'h00AA, 4'b0010, 1'b0);
        push_frame(32'h0303FEFF);
        q_ack.push_back(1'b1);
        wait_tick();

        // Two requests in one frame: one ack, latest inputs win.
        issue(16'h1111, 4'b0000, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        issue(16'h9876, 4'b0000, 1'b0);
        push_frame(32'h09011F41);
        q_ack.push_back(1'b1);
        wait_tick();

        // Request raised in the wrap cycle itself (39 cycles after the tick cycle).
        push_frame(32'hFFFFFF0D);
        q_ack.push_back(1'b1);
        repeat (39) @(posedge clk);
        #1;
        issue(16'h0003, 4'b0000, 1'b1);
        check("wrap_cycle_ack", upd_ack, 1);
        push_frame(32'hFFFFFF0D);

        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (sel_n == 4'b1011) break;
        end
        check("digit2_reached", 32'(k < 200), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midscan_reset_sel_n", sel_n, 4'hF);
        check("midscan_reset_seg", seg, 8'hFF);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_frame(32'h03030303);
        push_frame(32'h03030303);
        wait_tick();
        wait_tick();
        check("ack_queue_drained", q_ack.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
